// File: rtl/key_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_enc_pkg
// Brief    : Default constants and width helper for the key priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package key_enc_pkg;

  localparam int KEY_ENC_N_DEF   = 4;
  localparam int KEY_ENC_DEB_DEF = 500000;

  // ceil(log2(n)), never below one bit so single-value ranges still get a wire
  function automatic int key_enc_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop synchronizer plus counter-based debouncer for one key bit.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEB_CYC = 500000,
  parameter int CW      = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable
);

  localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // The stable state only moves after DEB_CYC consecutive mismatching samples;
  // any match in between throws the pending change away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/key_prio_encoder.sv
`default_nettype none
// ============================================================================
// Module   : key_prio_encoder
// Brief    : Debounced active-low keys -> registered highest-index code, valid
//            flag and new-code event. Define KEY_ENC_HOLD_EN to keep the last
//            code on full release.
// Revision : 1.0 - initial release
// ============================================================================
module key_prio_encoder
  import key_enc_pkg::*;
#(
  parameter  int N       = KEY_ENC_N_DEF,
  parameter  int DEB_CYC = KEY_ENC_DEB_DEF,
  localparam int W       = key_enc_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         evt
);

  localparam int CW = key_enc_width(DEB_CYC + 1);

  logic [N-1:0] w_stable;
  logic [N-1:0] w_active;
  logic         w_hit;
  logic [W-1:0] w_idx;
  logic [W-1:0] w_code_idle;
  logic [W-1:0] w_code_nxt;
  logic         w_evt_nxt;

  logic [W-1:0] r_code;
  logic         r_valid;
  logic         r_evt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_deb
      key_debounce #(
        .DEB_CYC (DEB_CYC),
        .CW      (CW)
      ) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key[gi]),
        .stable  (w_stable[gi])
      );
    end
  endgenerate

  assign w_active = ~w_stable;

  // Later iterations overwrite earlier ones, so the highest pressed index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_active[i]) begin
        w_hit = 1'b1;
        w_idx = W'(i);
      end
    end
  end

`ifdef KEY_ENC_HOLD_EN
  assign w_code_idle = r_code;
`else
  assign w_code_idle = '0;
`endif

  assign w_code_nxt = w_hit ? w_idx : w_code_idle;
  assign w_evt_nxt  = w_hit && (!r_valid || (w_idx != r_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_code  <= w_code_nxt;
      r_valid <= w_hit;
      r_evt   <= w_evt_nxt;
    end
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign evt   = r_evt;

endmodule
`default_nettype wire
